frame_scheduler: RTL and testbench
==================================

// Module: frame_scheduler
// PURPOSE
//   Sequences per-frame work for the video pipeline; sits between pixel_iterator and the RGB source mux.
//   On each vertical-sync start: requests one game-state update, waits for completion, then commits the
//   switch-selected video source, so source changes land only at frame boundaries (no tearing).
//   Supervises overrun and hung-update conditions.
// PARAMETERS
//   SEL_WIDTH        4      width of raw selector input and committed src_sel
//   FRAME_CNT_WIDTH  16     width of committed-frame counter (wraps)
//   TIMEOUT_CYCLES   65536  max clk_rgb cycles update_req may stay high before abort (>=2)
//   VS_ACTIVE        1'b1   active level of vs
// PORTS
//   clk_rgb      in   1                pixel clock, single clock domain
//   rst_n        in   1                reset, synchronous, active-low
//   vs           in   1                vertical sync from pixel_iterator
//   sel_in       in   SEL_WIDTH        raw selector (switches), asynchronous
//   update_done  in   1                one-cycle pulse from game logic: update finished
//   pause        in   1                freeze updates (only with FRAME_SCHED_PAUSE_EN)
//   update_req   out  1                level request to game logic, held until done/abort
//   src_sel      out  SEL_WIDTH        committed video source select
//   frame_cnt    out  FRAME_CNT_WIDTH  count of committed frames
//   busy         out  1                high in any state but IDLE
//   overrun      out  1                sticky: vs start seen while update outstanding
//   timeout_err  out  1                sticky: update aborted after TIMEOUT_CYCLES
// BEHAVIOUR
//   - Reset (rst_n=0 at clk_rgb edge): state IDLE; all outputs 0; sync/edge regs 0; timer 0.
//     Applies mid-transaction: update_req drops next cycle, a later update_done is ignored.
//   - sel_in passes a 2-flop synchronizer; sel_sync = sel_in delayed 2 cycles.
//   - vs registered to vs_q; vs_evt = (vs==VS_ACTIVE) && (vs_q!=VS_ACTIVE), combinational on cycle N.
//   - FSM:
//     IDLE   : on vs_evt latch pend_sel<=sel_sync, go REQ.
//     REQ    : update_req=1, timer<=0, go WAIT (update_req rises cycle N+1 after vs_evt).
//     WAIT   : update_req=1, timer++; update_done -> COMMIT; else timer==TIMEOUT_CYCLES-1 -> ABORT.
//     COMMIT : update_req=0, src_sel<=pend_sel, frame_cnt<=frame_cnt+1 (mod 2^FRAME_CNT_WIDTH), go IDLE.
//     ABORT  : update_req=0, timeout_err<=1, src_sel/frame_cnt unchanged, go IDLE.
//   - update_done outside WAIT is ignored. update_done and timeout on same cycle: done wins.
//   - vs_evt outside IDLE: overrun<=1, event dropped (no queueing), FSM continues.
//     vs_evt same cycle as update_done: done accepted, overrun set, event dropped.
//   - Minimum vs-to-commit latency: vs_evt cycle N, done on N+2 -> src_sel/frame_cnt update at N+4.
//   - Sticky flags clear only on reset.
// CONFIGURATION
//   FRAME_SCHED_PAUSE_EN defined: pause port exists, synchronized by 2 flops.
//     Synced pause=1 in IDLE: vs_evt only commits src_sel<=sel_sync directly (IDLE->COMMIT-like
//     path, no request, frame_cnt unchanged). Requests already outstanding complete normally.
//   FRAME_SCHED_PAUSE_EN undefined: no pause port, every vs_evt in IDLE starts a request.
// STRUCTURE
//   frame_sched_pkg: typedef enum logic [2:0] {IDLE,REQ,WAIT,COMMIT,ABORT} frame_sched_state_t;
//     timeout-counter width function (clog2 of TIMEOUT_CYCLES).
//   Sub-module sync_2ff (parameterized width) for sel_in and pause; reused elsewhere for buttons.
// TESTING
//   1 Reset, sel_in=1, vs pulse, done 3 cycles after update_req -> src_sel=1, frame_cnt=1, flags 0.
//   2 Done pulse same cycle update_req rises (N+2) -> commit at N+4; exact cycle checked.
//   3 TIMEOUT_CYCLES=8, no done -> update_req high 8 cycles, drops, timeout_err=1, src_sel unchanged.
//   4 Second vs rise while WAIT -> overrun=1, only one commit, frame_cnt+1 only.
//   5 rst_n low during WAIT, then done -> update_req 0, src_sel 0, frame_cnt 0, no commit.
//   6 FRAME_SCHED_PAUSE_EN, pause=1, sel_in=3, vs -> no update_req, src_sel=3, frame_cnt unchanged.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared types and helpers for the frame scheduler.
// Holds the FSM state encoding and the width helper for the update timer.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    COMMIT = 3'd3,
    ABORT  = 3'd4
  } frame_sched_state_t;

  // Bits needed to count 0..cycles-1, never less than one bit.
  function automatic int timer_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static asynchronous inputs (switches, buttons).
// Each bit is synchronized independently; there is no cross-bit coherence.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture into the local clock domain; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame work sequencer: on each vertical-sync start it requests one game-state
// update, waits for completion, then commits the switch-selected video source so
// source changes only happen at frame boundaries. Flags overruns and hung updates.
// Optional feature macro: FRAME_SCHED_PAUSE_EN adds a synchronized pause input that
// turns a vs start in IDLE into a direct source commit without an update request.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int   SEL_WIDTH       = 4,
  parameter int   FRAME_CNT_WIDTH = 16,
  parameter int   TIMEOUT_CYCLES  = 65536,
  parameter logic VS_ACTIVE       = 1'b1
) (
  input  logic                       clk_rgb,
  input  logic                       rst_n,
  input  logic                       vs,
  input  logic [SEL_WIDTH-1:0]       sel_in,
  input  logic                       update_done,
`ifdef FRAME_SCHED_PAUSE_EN
  input  logic                       pause,
`endif
  output logic                       update_req,
  output logic [SEL_WIDTH-1:0]       src_sel,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       busy,
  output logic                       overrun,
  output logic                       timeout_err
);

  localparam int                       TW         = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]            TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]            TIMER_ONE  = TW'(1);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_ONE  = FRAME_CNT_WIDTH'(1);

  frame_sched_state_t          r_state;
  logic                        r_vs_q;
  logic [SEL_WIDTH-1:0]        r_pend_sel;
  logic [TW-1:0]               r_timer;
  logic                        r_update_req;
  logic [SEL_WIDTH-1:0]        r_src_sel;
  logic [FRAME_CNT_WIDTH-1:0]  r_frame_cnt;
  logic                        r_overrun;
  logic                        r_timeout_err;

  logic [SEL_WIDTH-1:0]        w_sel_sync;
  logic                        w_vs_evt;
  logic                        w_pause_go;

  sync_2ff #(.WIDTH(SEL_WIDTH)) u_sel_sync (
    .clk   (clk_rgb),
    .rst_n (rst_n),
    .i_d   (sel_in),
    .o_q   (w_sel_sync)
  );

`ifdef FRAME_SCHED_PAUSE_EN
  logic w_pause_sync;

  sync_2ff #(.WIDTH(1)) u_pause_sync (
    .clk   (clk_rgb),
    .rst_n (rst_n),
    .i_d   (pause),
    .o_q   (w_pause_sync)
  );

  assign w_pause_go = w_pause_sync;
`else
  assign w_pause_go = 1'b0;
`endif

  // Start-of-vsync: active level now, inactive on the previous cycle.
  assign w_vs_evt = (vs == VS_ACTIVE) && (r_vs_q != VS_ACTIVE);

  // Scheduler FSM with registered outputs and sticky supervision flags.
  always_ff @(posedge clk_rgb) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_vs_q        <= 1'b0;
      r_pend_sel    <= '0;
      r_timer       <= '0;
      r_update_req  <= 1'b0;
      r_src_sel     <= '0;
      r_frame_cnt   <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_vs_q <= vs;

      // A frame start while still busy is dropped, not queued.
      if (w_vs_evt && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_vs_evt) begin
            if (w_pause_go) begin
              // Paused: take the new source at the boundary without touching game state.
              r_src_sel <= w_sel_sync;
            end else begin
              r_pend_sel <= w_sel_sync;
              r_state    <= REQ;
            end
          end
        end
        REQ: begin
          r_update_req <= 1'b1;
          r_timer      <= '0;
          r_state      <= WAIT;
        end
        WAIT: begin
          r_timer <= r_timer + TIMER_ONE;
          // Completion takes priority over a timeout expiring on the same cycle.
          if (update_done) begin
            r_update_req <= 1'b0;
            r_state      <= COMMIT;
          end else if (r_timer == TIMER_LAST) begin
            r_update_req <= 1'b0;
            r_state      <= ABORT;
          end
        end
        COMMIT: begin
          r_update_req <= 1'b0;
          r_src_sel    <= r_pend_sel;
          r_frame_cnt  <= r_frame_cnt + CNT_ONE;
          r_state      <= IDLE;
        end
        ABORT: begin
          r_update_req  <= 1'b0;
          r_timeout_err <= 1'b1;
          r_state       <= IDLE;
        end
        default: begin
          r_update_req <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign update_req  = r_update_req;
  assign src_sel     = r_src_sel;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = (r_state != IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed testbench for frame_scheduler (timeout shortened to 8 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_frame_scheduler;

  logic        clk;
  logic        rst_n;
  logic        vs;
  logic [3:0]  sel_in;
  logic        update_done;
`ifdef FRAME_SCHED_PAUSE_EN
  logic        pause;
`endif
  logic        update_req;
  logic [3:0]  src_sel;
  logic [15:0] frame_cnt;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  frame_scheduler #(
    .SEL_WIDTH       (4),
    .FRAME_CNT_WIDTH (16),
    .TIMEOUT_CYCLES  (8),
    .VS_ACTIVE       (1'b1)
  ) dut (
    .clk_rgb     (clk),
    .rst_n       (rst_n),
    .vs          (vs),
    .sel_in      (sel_in),
    .update_done (update_done),
`ifdef FRAME_SCHED_PAUSE_EN
    .pause       (pause),
`endif
    .update_req  (update_req),
    .src_sel     (src_sel),
    .frame_cnt   (frame_cnt),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      $display("[TB] check %s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int hi_cnt;

    rst_n       = 1'b0;
    vs          = 1'b0;
    sel_in      = 4'd0;
    update_done = 1'b0;
`ifdef FRAME_SCHED_PAUSE_EN
    pause       = 1'b0;
`endif
    tick(); tick(); tick();

    // Reset state
    check("rst_update_req", update_req, 0);
    check("rst_src_sel", src_sel, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;

    // Test 1: basic frame, done three cycles after update_req rises
    sel_in = 4'd1;
    tick(); tick(); tick();
    vs = 1'b1;
    tick();                                   // REQ
    vs = 1'b0;
    check("t1_busy_req", busy, 1);
    check("t1_req_not_yet", update_req, 0);
    tick();                                   // WAIT, request visible
    check("t1_req_high", update_req, 1);
    tick(); tick(); tick();
    update_done = 1'b1;
    tick();                                   // COMMIT
    update_done = 1'b0;
    check("t1_req_dropped", update_req, 0);
    check("t1_src_not_yet", src_sel, 0);
    tick();
    check("t1_src_sel", src_sel, 1);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_busy_idle", busy, 0);
    check("t1_overrun", overrun, 0);
    check("t1_timeout", timeout_err, 0);

    // Test 2: done on the first cycle update_req is high -> commit visible at N+4
    sel_in = 4'd2;
    tick(); tick(); tick();
    vs = 1'b1;                                // cycle N
    tick();                                   // N+1 (REQ)
    vs = 1'b0;
    tick();                                   // N+2 (WAIT)
    check("t2_req_high", update_req, 1);
    update_done = 1'b1;
    tick();                                   // N+3 (COMMIT)
    update_done = 1'b0;
    check("t2_src_n3", src_sel, 1);
    check("t2_cnt_n3", frame_cnt, 1);
    tick();                                   // N+4
    check("t2_src_n4", src_sel, 2);
    check("t2_cnt_n4", frame_cnt, 2);

    // update_done while idle is ignored
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    tick(); tick();
    check("idle_done_cnt", frame_cnt, 2);
    check("idle_done_busy", busy, 0);

    // Test 3: no done -> update_req high exactly 8 cycles, then abort
    sel_in = 4'd5;
    tick(); tick(); tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (update_req === 1'b1) hi_cnt++;
    end
    check("t3_req_cycles", hi_cnt, 8);
    check("t3_req_low", update_req, 0);
    check("t3_timeout", timeout_err, 1);
    check("t3_src_kept", src_sel, 2);
    check("t3_cnt_kept", frame_cnt, 2);
    check("t3_busy", busy, 0);

    // Test 4: second vs start during WAIT -> overrun, single commit
    sel_in = 4'd6;
    tick(); tick(); tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();                                   // WAIT
    tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    check("t4_overrun", overrun, 1);
    check("t4_busy", busy, 1);
    check("t4_req", update_req, 1);
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    tick();
    check("t4_src_sel", src_sel, 6);
    check("t4_frame_cnt", frame_cnt, 3);
    tick(); tick(); tick();
    check("t4_no_second_cnt", frame_cnt, 3);
    check("t4_no_second_busy", busy, 0);
    check("t4_overrun_sticky", overrun, 1);

    // Test 5: reset during WAIT, then a stale done
    sel_in = 4'd9;
    tick(); tick(); tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();                                   // WAIT
    check("t5_req_before", update_req, 1);
    rst_n = 1'b0;
    tick();
    check("t5_req_reset", update_req, 0);
    check("t5_src_reset", src_sel, 0);
    check("t5_cnt_reset", frame_cnt, 0);
    check("t5_overrun_reset", overrun, 0);
    check("t5_timeout_reset", timeout_err, 0);
    rst_n = 1'b1;
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    tick(); tick();
    check("t5_src_after", src_sel, 0);
    check("t5_cnt_after", frame_cnt, 0);
    check("t5_busy_after", busy, 0);

`ifdef FRAME_SCHED_PAUSE_EN
    // Test 6: paused -> direct source commit, no request, counter unchanged
    pause  = 1'b1;
    sel_in = 4'd3;
    tick(); tick(); tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    check("t6_req", update_req, 0);
    check("t6_busy", busy, 0);
    check("t6_src_sel", src_sel, 3);
    check("t6_frame_cnt", frame_cnt, 0);
    tick(); tick();
    check("t6_req_later", update_req, 0);
    pause = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
